// File: rtl/bist_pkg.sv
// Shared types and default parameters for the BIST pattern generator / response analyzer.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMPACT = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam int         DEF_WIDTH     = 8;
  localparam int         DEF_CNT_W     = 16;
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED = 8'h01;
  localparam logic [7:0] DEF_MISR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_MISR_SEED = 8'h00;
  localparam logic [7:0] DEF_GOLDEN    = 8'h00;

endpackage

// File: rtl/bist_lfsr.sv
// Shift register with XOR feedback; with din tied low it is a plain LFSR,
// with din driven by a response it acts as a MISR.
module bist_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= seed;
    end else if (enable) begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)} ^ din;
    end
  end

endmodule

// File: rtl/bist_tpg_ora.sv
// BIST test-pattern generator and output-response analyzer: LFSR stimulus,
// MISR compaction, pattern counter and a latched signature compare.
module bist_tpg_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS),
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEF_LFSR_SEED),
  parameter logic [WIDTH-1:0] MISR_TAPS = WIDTH'(DEF_MISR_TAPS),
  parameter logic [WIDTH-1:0] MISR_SEED = WIDTH'(DEF_MISR_SEED),
  parameter logic [WIDTH-1:0] GOLDEN    = WIDTH'(DEF_GOLDEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             toggle,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pattern_cnt,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output state_t           state_dbg
);

  if (WIDTH < 2) begin : g_bad_width
    $error("bist_tpg_ora: WIDTH must be at least 2");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bist_tpg_ora: LFSR_SEED must be nonzero");
  end

  state_t           state, state_nxt;
  logic             load, step;
  logic             res_set, res_pass;
  logic [WIDTH-1:0] lfsr;

  bist_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (step),
    .seed   (LFSR_SEED),
    .din    ('0),
    .q      (lfsr)
  );

  bist_lfsr #(.WIDTH(WIDTH), .TAPS(MISR_TAPS)) u_misr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (step),
    .seed   (MISR_SEED),
    .din    (cut_out),
    .q      (signature)
  );

  assign pattern   = lfsr ^ {WIDTH{toggle}};
  assign state_dbg = state;

  // Priority init > finish > running; a finish with nothing armed reports a failed run.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    res_set   = 1'b0;
    res_pass  = 1'b0;
    if (init) begin
      load      = 1'b1;
      state_nxt = ARMED;
    end else if (finish) begin
      case (state)
        IDLE: begin
          res_set   = 1'b1;
          state_nxt = RESULT;
        end
        ARMED, COMPACT: begin
          res_set   = 1'b1;
          res_pass  = (signature == GOLDEN);
          state_nxt = RESULT;
        end
        default: ;
      endcase
    end else if (running && (state == ARMED || state == COMPACT)) begin
      step      = 1'b1;
      state_nxt = COMPACT;
    end
  end

  // done qualifies pass/fail: once set, all three hold until init or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pattern_cnt <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        pattern_cnt <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
      end else begin
        if (step && pattern_cnt != '1) begin
          pattern_cnt <= pattern_cnt + 1'b1;
        end
        if (res_set) begin
          done <= 1'b1;
          pass <= res_pass;
          fail <= !res_pass;
        end
      end
    end
  end

endmodule

// File: tb/tb_bist_tpg_ora.sv
// Randomized and directed bench for bist_tpg_ora with a behavioural model and scoreboard.
module tb_bist_tpg_ora;
  import bist_pkg::*;

  localparam int         W  = 4;
  localparam int         CW = 4;
  localparam logic [W-1:0] LT = 4'b1001;
  localparam logic [W-1:0] LS = 4'b0001;
  localparam logic [W-1:0] MT = 4'b1001;
  localparam logic [W-1:0] MS = 4'b0001;
  localparam logic [W-1:0] GD = 4'b1111;
  localparam int         SW = W + W + CW + 3 + 2;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset, init, running, toggle, finish;
  logic [W-1:0]  cut_out, pattern, signature;
  logic [CW-1:0] pattern_cnt;
  logic          done, pass, fail;
  state_t        state_dbg;

  bist_tpg_ora #(
    .WIDTH(W), .CNT_W(CW), .LFSR_TAPS(LT), .LFSR_SEED(LS),
    .MISR_TAPS(MT), .MISR_SEED(MS), .GOLDEN(GD)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .running(running), .toggle(toggle),
    .finish(finish), .cut_out(cut_out), .pattern(pattern), .signature(signature),
    .pattern_cnt(pattern_cnt), .done(done), .pass(pass), .fail(fail),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] m_lfsr = LS;
  logic [W-1:0] m_misr = MS;
  int           m_cnt  = 0;
  logic         m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0;
  state_t       m_st   = IDLE;

  logic [SW-1:0] exp_q[$];
  logic [1:0]    res_q[$];
  int            checks = 0;
  int            passed = 0;
  logic          prev_done = 1'b0;

  function automatic logic [W-1:0] shift_fb(logic [W-1:0] x, logic [W-1:0] taps);
    int ones = 0;
    for (int i = 0; i < W; i++) if (x[i] && taps[i]) ones++;
    return W'((int'(x) * 2 + ones % 2) % (1 << W));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // driver: apply one cycle of inputs, record expected outputs, advance the model
  task automatic cyc(input bit rst, input bit ini, input bit fin, input bit run,
                     input bit tog, input logic [W-1:0] co);
    logic was_done;
    reset = rst; init = ini; finish = fin; running = run; toggle = tog; cut_out = co;
    exp_q.push_back({m_lfsr ^ {W{tog}}, m_misr, CW'(m_cnt), m_done, m_pass, m_fail, m_st});
    was_done = m_done;
    if (rst || ini) begin
      m_lfsr = LS; m_misr = MS; m_cnt = 0;
      m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
      m_st = rst ? IDLE : ARMED;
    end else if (fin) begin
      if (m_st == IDLE) begin
        m_done = 1'b1; m_pass = 1'b0; m_fail = 1'b1; m_st = RESULT;
      end else if (m_st != RESULT) begin
        m_done = 1'b1; m_pass = (m_misr == GD); m_fail = !m_pass; m_st = RESULT;
      end
    end else if (run && (m_st == ARMED || m_st == COMPACT)) begin
      m_lfsr = shift_fb(m_lfsr, LT);
      m_misr = shift_fb(m_misr, MT) ^ co;
      m_cnt  = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_st   = COMPACT;
    end
    if (m_done && !was_done) res_q.push_back({m_pass, m_fail});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, W'($urandom_range(0, 15)));
  endtask

  // monitor: per-cycle snapshot compare plus a result compare on each done rise
  always @(negedge clk) begin
    logic [SW-1:0] e;
    logic [W-1:0]  e_pat, e_sig;
    logic [CW-1:0] e_cnt;
    logic          e_done, e_pass, e_fail;
    logic [1:0]    e_st, r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {e_pat, e_sig, e_cnt, e_done, e_pass, e_fail, e_st} = e;
      check("pattern",     32'(pattern),     32'(e_pat));
      check("signature",   32'(signature),   32'(e_sig));
      check("pattern_cnt", 32'(pattern_cnt), 32'(e_cnt));
      check("done_level",  32'(done),        32'(e_done));
      check("pass_level",  32'(pass),        32'(e_pass));
      check("fail_level",  32'(fail),        32'(e_fail));
      check("state",       32'(state_dbg),   32'(e_st));
    end
    if (done === 1'b1 && !prev_done) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        r = res_q.pop_front();
        check("result_pass", 32'(pass), 32'(r[1]));
        check("result_fail", 32'(fail), 32'(r[0]));
      end
    end
    prev_done = (done === 1'b1);
  end

  initial begin
    reset = 1'b1; init = 1'b0; finish = 1'b0; running = 1'b0; toggle = 1'b0; cut_out = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 1, '0);               // pattern = ~seed during reset
    // full LFSR period then counter saturation
    cyc(0, 1, 0, 0, 0, '0);
    run_n(15);
    idle(1);
    run_n(2);
    idle(1);
    // matching signature run
    cyc(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    idle(2);
    // corrupted response in the second pattern
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 4'b0000);
    cyc(0, 0, 0, 1, 0, 4'b0001);
    cyc(0, 0, 0, 1, 0, 4'b0000);
    cyc(0, 0, 1, 0, 0, '0);
    idle(2);
    // toggle inverts pattern without disturbing the LFSR
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, 1, '0);
    run_n(2);
    // init mid-run, then a clean passing run
    cyc(0, 1, 0, 0, 0, '0);
    run_n(5);
    cyc(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    idle(1);
    // finish without init; later finish/running in RESULT are ignored
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    idle(1);
    cyc(0, 0, 1, 1, 0, 4'b0110);
    cyc(0, 0, 0, 1, 0, 4'b0011);
    idle(1);
    // running and finish together: compare sees pre-update MISR
    cyc(0, 1, 0, 0, 0, '0);
    run_n(2);
    cyc(0, 0, 1, 1, 0, 4'b1010);
    idle(1);
    // reset during COMPACT, then running without init
    cyc(0, 1, 0, 0, 0, '0);
    run_n(3);
    cyc(1, 0, 1, 1, 0, 4'b0101);
    run_n(2);
    idle(1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, W'($urandom_range(0, 15)));
    end
    idle(2);
    @(negedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
